// File: rtl/spi_tx_scheduler_if.sv
// Requester/transmitter bundle for spi_tx_scheduler. The master modport is the
// scheduler side; the slave modport is the requesters plus the SPI transmitter.
interface spi_tx_scheduler_if #(
  parameter int NUM_REQ = 4
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0]    i_Req_Valid;
  logic [14*NUM_REQ-1:0] i_Req_Word;
  logic [NUM_REQ-1:0]    o_Req_Ack;
  logic [13:0]           o_TX_Word;
  logic                  o_TX_DV;
  logic                  i_TX_Ready;
  logic                  o_Busy;
  logic [GW-1:0]         o_Grant_Id;
  logic                  o_Timeout;

  modport master (
    input  i_Req_Valid, i_Req_Word, i_TX_Ready,
    output o_Req_Ack, o_TX_Word, o_TX_DV, o_Busy, o_Grant_Id, o_Timeout
  );

  modport slave (
    output i_Req_Valid, i_Req_Word, i_TX_Ready,
    input  o_Req_Ack, o_TX_Word, o_TX_DV, o_Busy, o_Grant_Id, o_Timeout
  );
endinterface

// File: rtl/spi_tx_scheduler.sv
// Round-robin scheduler sharing one 14-bit SPI transmitter among NUM_REQ requesters.
// Define SPI_TX_SCHED_WDOG_EN to build the frame watchdog and sticky o_Timeout.
module spi_tx_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int WDOG_CYCLES = 1024
) (
  input  logic                i_Clk,
  input  logic                i_Rst,
  spi_tx_scheduler_if.master  bus
);
  localparam int GW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GW-1:0] LAST = GW'(NUM_REQ - 1);

  if (NUM_REQ < 2 || NUM_REQ > 8 || GAP_CYCLES < 0 || WDOG_CYCLES < 2) begin : g_bad_param
    $error("spi_tx_scheduler: illegal parameter value");
  end

  typedef enum logic [2:0] {IDLE, ISSUE, WAIT_BUSY, WAIT_DONE, GAP} state_e;

  state_e             state_q, state_d;
  logic [NUM_REQ-1:0] ack_q, ack_d;
  logic [13:0]        word_q, word_d;
  logic               dv_q, dv_d;
  logic               busy_q, busy_d;
  logic [GW-1:0]      gid_q, gid_d;
  logic [CW-1:0]      gap_q, gap_d;
  logic [GW-1:0]      pick, cand;
  logic               found;
  logic [13:0]        words [NUM_REQ];

  for (genvar k = 0; k < NUM_REQ; k++) begin : g_unpack
    assign words[k] = bus.i_Req_Word[14*k +: 14];
  end

`ifdef SPI_TX_SCHED_WDOG_EN
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  logic [WW-1:0] wdog_q, wdog_d;
  logic          tout_q, tout_d;
  logic          wdog_hit;
  assign wdog_hit      = (wdog_q == WW'(WDOG_CYCLES - 1));
  assign bus.o_Timeout = tout_q;
`else
  assign bus.o_Timeout = 1'b0;
`endif

  // Search starts just past the last grant, so the previous winner is checked last.
  always_comb begin
    found = 1'b0;
    pick  = gid_q;
    cand  = gid_q;
    for (int off = 1; off <= NUM_REQ; off++) begin
      cand = GW'((int'(gid_q) + off) % NUM_REQ);
      if (!found && bus.i_Req_Valid[cand]) begin
        found = 1'b1;
        pick  = cand;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    ack_d   = '0;
    word_d  = word_q;
    dv_d    = 1'b0;
    gid_d   = gid_q;
    gap_d   = gap_q;
`ifdef SPI_TX_SCHED_WDOG_EN
    wdog_d  = wdog_q;
    tout_d  = tout_q;
`endif
    case (state_q)
      IDLE: begin
        if (bus.i_TX_Ready && found) begin
          word_d      = words[pick];
          gid_d       = pick;
          ack_d[pick] = 1'b1;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        dv_d    = 1'b1;
        state_d = WAIT_BUSY;
`ifdef SPI_TX_SCHED_WDOG_EN
        wdog_d  = '0;
`endif
      end
      WAIT_BUSY: begin
        if (!bus.i_TX_Ready) begin
          state_d = WAIT_DONE;
`ifdef SPI_TX_SCHED_WDOG_EN
          wdog_d  = '0;
        end else if (wdog_hit) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end else begin
          wdog_d  = wdog_q + 1'b1;
`endif
        end
      end
      WAIT_DONE: begin
        if (bus.i_TX_Ready) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            gap_d   = CW'(GAP_CYCLES - 1);
            state_d = GAP;
          end
`ifdef SPI_TX_SCHED_WDOG_EN
        end else if (wdog_hit) begin
          state_d = IDLE;
          tout_d  = 1'b1;
        end else begin
          wdog_d  = wdog_q + 1'b1;
`endif
        end
      end
      GAP: begin
        if (gap_q == '0) state_d = IDLE;
        else             gap_d   = gap_q - 1'b1;
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d != IDLE);
  end

  always_ff @(posedge i_Clk) begin
    if (i_Rst) begin
      state_q <= IDLE;
      ack_q   <= '0;
      word_q  <= '0;
      dv_q    <= 1'b0;
      busy_q  <= 1'b0;
      gid_q   <= LAST;
      gap_q   <= '0;
`ifdef SPI_TX_SCHED_WDOG_EN
      wdog_q  <= '0;
      tout_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      ack_q   <= ack_d;
      word_q  <= word_d;
      dv_q    <= dv_d;
      busy_q  <= busy_d;
      gid_q   <= gid_d;
      gap_q   <= gap_d;
`ifdef SPI_TX_SCHED_WDOG_EN
      wdog_q  <= wdog_d;
      tout_q  <= tout_d;
`endif
    end
  end

  assign bus.o_Req_Ack  = ack_q;
  assign bus.o_TX_Word  = word_q;
  assign bus.o_TX_DV    = dv_q;
  assign bus.o_Busy     = busy_q;
  assign bus.o_Grant_Id = gid_q;
endmodule

// File: tb/tb_spi_tx_scheduler.sv
// Scoreboard bench for spi_tx_scheduler: expected grants are queued as requests are
// posted and popped when an ack appears; a small transmitter model drives ready.
module tb_spi_tx_scheduler;
  localparam int NR = 4, GAP = 3, WDOG = 16, FRAME = 14;

  logic i_Clk = 1'b0;
  logic i_Rst = 1'b1;
  always #5 i_Clk = ~i_Clk;

  spi_tx_scheduler_if #(.NUM_REQ(NR)) bus ();
  spi_tx_scheduler #(.NUM_REQ(NR), .GAP_CYCLES(GAP), .WDOG_CYCLES(WDOG)) dut (
    .i_Clk(i_Clk), .i_Rst(i_Rst), .bus(bus)
  );

  typedef struct packed { logic [1:0] id; logic [13:0] word; } exp_t;
  exp_t sb_q[$];
  exp_t e;

  int n_chk = 0, n_fail = 0, cyc = 0;
  int frame_cnt = 0, rise_cyc = 0, ack_cyc = 0, ack_cnt = 0, dv_cnt = 0;
  int rearm [NR];
  logic [13:0]   word_r [NR];
  logic [NR-1:0] valid_r = '0, ack_seen = '0;
  logic dv_seen = 1'b0, prev_ack = 1'b0, tx_auto = 1'b1, gap_chk = 1'b0, rise_vld = 1'b0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic drive();
    bus.i_Req_Valid = valid_r;
    for (int k = 0; k < NR; k++) bus.i_Req_Word[14*k +: 14] = word_r[k];
  endtask

  // One clock: requesters react to last cycle's ack, transmitter model advances.
  task automatic tick();
    @(posedge i_Clk);
    #1;
    cyc++;
    for (int k = 0; k < NR; k++) begin
      if (ack_seen[k]) begin
        if (rearm[k] > 0) begin
          rearm[k]--;
          word_r[k] = word_r[k] + 14'h1;
        end else begin
          valid_r[k] = 1'b0;
        end
      end
    end
    ack_seen = '0;
    if (tx_auto) begin
      if (dv_seen) frame_cnt = FRAME;
      if (frame_cnt > 0) begin
        bus.i_TX_Ready = 1'b0;
        frame_cnt--;
      end else if (!bus.i_TX_Ready) begin
        bus.i_TX_Ready = 1'b1;
        rise_cyc = cyc;
        rise_vld = 1'b1;
      end
    end
    dv_seen = 1'b0;
    drive();
  endtask

  task automatic wait_acks(input int target, input int bound, input string tag);
    int n;
    n = 0;
    while (ack_cnt < target && n < bound) begin
      tick();
      n++;
    end
    chk({tag, "_ack_arrived"}, ack_cnt >= target, 1);
  endtask

  task automatic wait_idle(input int bound);
    int n;
    n = 0;
    while (!(!bus.o_Busy && bus.i_TX_Ready && frame_cnt == 0) && n < bound) begin
      tick();
      n++;
    end
    chk("idle_reached", !bus.o_Busy && bus.i_TX_Ready, 1);
  endtask

  // Output monitor, sampling on the falling edge.
  always @(negedge i_Clk) begin
    if (i_Rst) begin
      prev_ack = 1'b0;
    end else begin
      if (prev_ack || bus.o_TX_DV) chk("tx_dv_after_ack", bus.o_TX_DV, prev_ack);
      if (bus.o_TX_DV) begin
        dv_cnt++;
        dv_seen = 1'b1;
      end
      prev_ack = |bus.o_Req_Ack;
      if (|bus.o_Req_Ack) begin
        ack_cnt++;
        ack_cyc  = cyc;
        ack_seen = ack_seen | bus.o_Req_Ack;
        chk("ack_onehot", $onehot(bus.o_Req_Ack), 1);
        chk("busy_with_ack", bus.o_Busy, 1);
        if (sb_q.size() == 0) begin
          chk("unexpected_ack", bus.o_Req_Ack, 0);
        end else begin
          e = sb_q.pop_front();
          chk("ack_id", bus.o_Req_Ack, 1 << e.id);
          chk("grant_id", bus.o_Grant_Id, e.id);
          chk("tx_word", bus.o_TX_Word, e.word);
        end
        // Ready driven high in cycle r is seen during r; the grant decision lands
        // GAP+1 cycles later and the registered ack shows one cycle after that.
        if (gap_chk && rise_vld) chk("gap_spacing", ack_cyc, rise_cyc + GAP + 2);
        rise_vld = 1'b0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_time_limit: got no end of test, expected finish");
    $fatal(1);
  end

  initial begin
    int c0, a, base;
    for (int k = 0; k < NR; k++) begin
      word_r[k] = '0;
      rearm[k]  = 0;
    end
    bus.i_TX_Ready = 1'b1;
    bus.i_Req_Word = '0;
    drive();
    repeat (3) tick();

    chk("rst_ack", bus.o_Req_Ack, 0);
    chk("rst_word", bus.o_TX_Word, 0);
    chk("rst_dv", bus.o_TX_DV, 0);
    chk("rst_busy", bus.o_Busy, 0);
    chk("rst_grant_id", bus.o_Grant_Id, NR - 1);
    chk("rst_timeout", bus.o_Timeout, 0);
    i_Rst = 1'b0;
    tick();

    // Single request from requester 2.
    valid_r[2] = 1'b1;
    word_r[2]  = 14'h2A5C;
    sb_q.push_back(exp_t'{2'd2, 14'h2A5C});
    drive();
    c0 = cyc;
    wait_acks(1, 10, "single");
    chk("single_ack_latency", ack_cyc - c0, 1);
    wait_idle(100);

    // Reset while waiting for the frame to finish.
    valid_r[1] = 1'b1;
    word_r[1]  = 14'h1555;
    sb_q.push_back(exp_t'{2'd1, 14'h1555});
    drive();
    wait_acks(2, 10, "midrst");
    repeat (6) tick();
    chk("midrst_busy_before", bus.o_Busy, 1);
    valid_r[0] = 1'b1;
    word_r[0]  = 14'h0AAA;
    valid_r[3] = 1'b1;
    word_r[3]  = 14'h3333;
    sb_q.push_back(exp_t'{2'd0, 14'h0AAA});
    sb_q.push_back(exp_t'{2'd3, 14'h3333});
    i_Rst = 1'b1;
    drive();
    tick();
    chk("midrst_ack", bus.o_Req_Ack, 0);
    chk("midrst_word", bus.o_TX_Word, 0);
    chk("midrst_dv", bus.o_TX_DV, 0);
    chk("midrst_busy", bus.o_Busy, 0);
    chk("midrst_grant_id", bus.o_Grant_Id, NR - 1);
    i_Rst = 1'b0;
    wait_acks(3, 40, "midrst_regrant");
    chk("midrst_grant_after_ready", ack_cyc, rise_cyc + 1);
    wait_acks(4, 60, "midrst_second");
    wait_idle(100);

    // All four requesters valid for two words each.
    gap_chk  = 1'b1;
    rise_vld = 1'b0;
    base     = ack_cnt;
    c0       = dv_cnt;
    for (int n = 0; n < 2; n++)
      for (int k = 0; k < NR; k++)
        sb_q.push_back(exp_t'{2'(k), 14'((k + 1) * 256 + n)});
    for (int k = 0; k < NR; k++) begin
      valid_r[k] = 1'b1;
      word_r[k]  = 14'((k + 1) * 256);
      rearm[k]   = 1;
    end
    drive();
    wait_acks(base + 8, 400, "rr");
    wait_idle(100);
    chk("rr_one_strobe_per_grant", dv_cnt - c0, 8);
    gap_chk = 1'b0;

    // Ready held low in IDLE with requests pending.
    tx_auto        = 1'b0;
    bus.i_TX_Ready = 1'b0;
    valid_r[1] = 1'b1;
    word_r[1]  = 14'h0F0F;
    valid_r[2] = 1'b1;
    word_r[2]  = 14'h3C3C;
    sb_q.push_back(exp_t'{2'd1, 14'h0F0F});
    sb_q.push_back(exp_t'{2'd2, 14'h3C3C});
    drive();
    base = ack_cnt;
    c0   = dv_cnt;
    repeat (50) tick();
    chk("hold_no_ack", ack_cnt - base, 0);
    chk("hold_no_dv", dv_cnt - c0, 0);
    chk("hold_not_busy", bus.o_Busy, 0);
    bus.i_TX_Ready = 1'b1;
    tx_auto        = 1'b1;
    c0 = cyc;
    wait_acks(base + 1, 10, "hold_release");
    chk("hold_release_latency", ack_cyc - c0, 1);
    wait_acks(base + 2, 60, "hold_second");
    wait_idle(100);

`ifdef SPI_TX_SCHED_WDOG_EN
    // Transmitter never drops ready: watchdog must fire.
    tx_auto        = 1'b0;
    bus.i_TX_Ready = 1'b1;
    valid_r[0] = 1'b1;
    word_r[0]  = 14'h2222;
    sb_q.push_back(exp_t'{2'd0, 14'h2222});
    drive();
    wait_acks(ack_cnt + 1, 10, "wdog");
    a = ack_cyc;
    while (cyc < a + WDOG) tick();
    chk("wdog_pre_timeout", bus.o_Timeout, 0);
    chk("wdog_pre_busy", bus.o_Busy, 1);
    tick();
    chk("wdog_timeout_set", bus.o_Timeout, 1);
    chk("wdog_forced_idle", bus.o_Busy, 0);
    repeat (10) tick();
    chk("wdog_timeout_sticky", bus.o_Timeout, 1);
    i_Rst = 1'b1;
    tick();
    chk("wdog_timeout_cleared", bus.o_Timeout, 0);
    i_Rst = 1'b0;
    tick();
    tx_auto = 1'b1;
`else
    a = 0;
    chk("timeout_tied_low", bus.o_Timeout, a);
`endif

    chk("scoreboard_empty", sb_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
